// File: rtl/mux4way16bit_arbiter.sv
// Round-robin owner selection for four 16-bit requesters; the chosen word is registered onto one shared output.
// Latency: grant one cycle after req; data appears one cycle after being presented by the owner (none in the first grant cycle).
// Backpressure: none; requests are level-held until granted. Optional macro ARB_TIMEOUT_EN caps the hold time at MAX_HOLD.
module mux4way16bit_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] inA,
    input  logic [15:0] inB,
    input  logic [15:0] inC,
    input  logic [15:0] inD,
    output logic [3:0]  grant,
    output logic [1:0]  select,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    // Reject configurations where the hold counter cannot reach MAX_HOLD.
    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("mux4way16bit_arbiter: illegal MAX_HOLD/HOLD_W combination");
    end

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_grant, w_grant_nxt;
    logic [1:0]  r_select, w_select_nxt;
    logic [1:0]  r_last, w_last_nxt;
    logic [15:0] r_out, w_out_nxt;
    logic        r_vld, w_vld_nxt;
    logic [1:0]  w_scan_from;
    logic [1:0]  w_probe;
    logic [1:0]  w_win_idx;
    logic        w_win_vld;
    logic [15:0] w_word;
`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
`endif

    assign w_scan_from = r_last + 2'd1;

    // Round-robin scan: walk offsets from far to near so the nearest request after the last owner wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        w_probe   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_probe = w_scan_from + 2'(i);
            if (req[w_probe]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_probe;
            end
        end
    end

    // Shared 4-way data mux steered by the registered select.
    always_comb begin
        case (r_select)
            2'd0:    w_word = inA;
            2'd1:    w_word = inB;
            2'd2:    w_word = inC;
            default: w_word = inD;
        endcase
    end

    // Next-state and next-register values for the IDLE/GRANT sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_select_nxt = r_select;
        w_last_nxt   = r_last;
        w_out_nxt    = r_out;
        w_vld_nxt    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt   = r_hold;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt  = ST_GRANT;
                    w_grant_nxt  = 4'b0001 << w_win_idx;
                    w_select_nxt = w_win_idx;
                    w_last_nxt   = w_win_idx;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt   = '0;
`endif
                end
            end
            default: begin
                if (req[r_select]) begin
                    // Owner still requesting: transfer its word this edge.
                    w_out_nxt = w_word;
                    w_vld_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    // Hold budget used up: transfer, then hand over (may regrant the same owner).
                    if (r_hold == HOLD_W'(MAX_HOLD - 1)) begin
                        w_grant_nxt  = 4'b0001 << w_win_idx;
                        w_select_nxt = w_win_idx;
                        w_last_nxt   = w_win_idx;
                        w_hold_nxt   = '0;
                    end else begin
                        w_hold_nxt   = r_hold + 1'b1;
                    end
`endif
                end else if (w_win_vld) begin
                    // Owner released with others waiting: switch directly, no idle bubble.
                    w_grant_nxt  = 4'b0001 << w_win_idx;
                    w_select_nxt = w_win_idx;
                    w_last_nxt   = w_win_idx;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt   = '0;
`endif
                end else begin
                    // Nobody left: drop to idle, select keeps its last value.
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                end
            end
        endcase
    end

    // State and datapath registers; reset overrides everything including an active grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= 4'b0000;
            r_select <= 2'd0;
            r_last   <= 2'd3;
            r_out    <= 16'h0000;
            r_vld    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold   <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_select <= w_select_nxt;
            r_last   <= w_last_nxt;
            r_out    <= w_out_nxt;
            r_vld    <= w_vld_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold   <= w_hold_nxt;
`endif
        end
    end

    // Outputs come straight from registers; busy reflects the GRANT state.
    always_comb begin
        grant     = r_grant;
        select    = r_select;
        out       = r_out;
        out_valid = r_vld;
        busy      = (r_state == ST_GRANT);
    end

endmodule

// File: tb/tb_mux4way16bit_arbiter.sv
// Self-checking bench for mux4way16bit_arbiter: directed scenarios plus random traffic against a cycle model.
// The model tracks owner/last-owner as plain integers and applies the round-robin rules directly.
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns after the edge.
module tb_mux4way16bit_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] inA, inB, inC, inD;
    logic [3:0]  grant;
    logic [1:0]  select;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;

    always #5 clk = ~clk;

    mux4way16bit_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .inA(inA), .inB(inB), .inC(inC), .inD(inD),
        .grant(grant), .select(select), .out(out),
        .out_valid(out_valid), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_owner;   // -1 when idle
    int          m_last;
    int          m_sel;
    int          m_hold;    // transfers completed in the current grant
    int          m_xfer;    // requester that transferred on the last edge, -1 if none
    logic [15:0] m_out;
    logic        m_vld;

    function automatic int pick(input logic [3:0] r, input int from);
        for (int i = 0; i < 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner = w;
        m_sel   = w;
        m_last  = w;
        m_hold  = 0;
    endtask

    task automatic model_step();
        logic [15:0] words [4];
        int w;
        words[0] = inA; words[1] = inB; words[2] = inC; words[3] = inD;
        m_xfer = -1;
        if (reset) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;
            m_out = 16'h0; m_vld = 1'b0;
        end else if (m_owner < 0) begin
            m_vld = 1'b0;
            w = pick(req, (m_last + 1) % 4);
            if (w >= 0) take(w);
        end else if (req[m_owner]) begin
            m_out  = words[m_owner];
            m_vld  = 1'b1;
            m_xfer = m_owner;
            m_hold++;
`ifdef ARB_TIMEOUT_EN
            if (m_hold == MAX_HOLD) take(pick(req, (m_owner + 1) % 4));
`endif
        end else begin
            m_vld = 1'b0;
            w = pick(req, (m_owner + 1) % 4);
            if (w >= 0) take(w);
            else m_owner = -1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("select", 32'(select), 32'(m_sel));
        check("out", 32'(out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic rand_data();
        inA = 16'($urandom); inB = 16'($urandom);
        inC = 16'($urandom); inD = 16'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'b0000;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  mask;
        int          cnt [4];
        int          order [$];
        int          prev;
        logic [15:0] kept;

        reset = 1'b1; req = 4'b0000;
        inA = 16'h0; inB = 16'h0; inC = 16'h0; inD = 16'h0;
        m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0; m_xfer = -1;
        m_out = 16'h0; m_vld = 1'b0;

        // Reset state and first transfer
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        req = 4'b0001; inA = 16'h1234;
        cycle();
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_select", 32'(select), 32'd0);
        check("t1_vld0", 32'(out_valid), 32'd0);
        cycle();
        check("t1_out", 32'(out), 32'h1234);
        check("t1_vld1", 32'(out_valid), 32'd1);

        // Round robin with all requesting, each dropping after two transfers
        do_reset();
        mask = 4'b1111; prev = -1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 40 && mask != 4'b0000; c++) begin
            req = mask; rand_data();
            cycle();
            check("rr_busy", 32'(busy), 32'd1);
            if (m_xfer >= 0) cnt[m_xfer]++;
            if (m_owner >= 0 && m_owner != prev) begin
                order.push_back(m_owner);
                prev = m_owner;
            end
            for (int i = 0; i < 4; i++) if (cnt[i] >= 2) mask[i] = 1'b0;
        end
        check("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) check("rr_order", 32'(order[i]), 32'(i));

        // Owner 2 releases to idle, then wrap-around scan picks requester 0
        do_reset();
        req = 4'b0100; rand_data();
        cycle(); cycle(); cycle();
        kept = out;
        check("idle_kept_model", 32'(kept), 32'(inC));
        req = 4'b0000;
        cycle();
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_vld", 32'(out_valid), 32'd0);
        check("idle_out", 32'(out), 32'(kept));
        check("idle_select", 32'(select), 32'd2);
        req = 4'b0101;
        cycle();
        check("wrap_grant", 32'(grant), 32'd1);

        // Reset in the middle of a grant
        do_reset();
        req = 4'b1000; rand_data();
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0; req = 4'b1001;
        cycle();
        check("postrst_grant", 32'(grant), 32'd1);

`ifdef ARB_TIMEOUT_EN
        // Forced hand-over after MAX_HOLD transfers
        do_reset();
        req = 4'b0011;
        cycle();
        for (int k = 1; k <= MAX_HOLD; k++) begin
            rand_data();
            cycle();
            check("to_grant", 32'(grant), (k < MAX_HOLD) ? 32'd1 : 32'd2);
        end
        check("to_vld", 32'(out_valid), 32'd1);
        // Sole requester is regranted with continuous valid
        do_reset();
        req = 4'b0001;
        cycle();
        for (int k = 0; k < 3 * MAX_HOLD; k++) begin
            rand_data();
            cycle();
            check("solo_grant", 32'(grant), 32'd1);
            check("solo_vld", 32'(out_valid), 32'd1);
        end
`else
        // Without the timeout the first owner keeps the grant indefinitely
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 100; k++) begin
            rand_data();
            cycle();
            check("hold_grant", 32'(grant), 32'd1);
        end
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_data();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
